// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tc_pkg
//  Description : Shared tensor-core definitions: the 64-bit GEMM command
//                layout, host register map, CTRL bit positions and the
//                command legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package tc_pkg;

  // Packed MSB first, so len_m occupies bits [7:0] and addr_d bits [63:54].
  typedef struct packed {
    logic [9:0] addr_d;
    logic [9:0] addr_c;
    logic [9:0] addr_b;
    logic [9:0] addr_a;
    logic [7:0] len_n;
    logic [7:0] len_k;
    logic [7:0] len_m;
  } command_t;

  // Host register map
  localparam logic [1:0] CMD_LO = 2'd0;
  localparam logic [1:0] CMD_HI = 2'd1;
  localparam logic [1:0] CTRL   = 2'd2;

  // CTRL register bit positions
  localparam int unsigned CTRL_IRQ_EN  = 0;
  localparam int unsigned CTRL_IRQ_CLR = 1;
  localparam int unsigned CTRL_ERR_CLR = 2;

  // Every dimension must be in 1..w for the array to execute the command.
  function automatic logic cmd_is_legal(input command_t c, input int unsigned w);
    return (c.len_m != 8'd0) && (32'(c.len_m) <= w) &&
           (c.len_k != 8'd0) && (32'(c.len_k) <= w) &&
           (c.len_n != 8'd0) && (32'(c.len_n) <= w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with an occupancy count. A push while full
//                is accepted when a pop happens in the same cycle.
//  Ports       : clk, rst_n     - clock, synchronous active-low reset
//                i_push, i_data - write request and data
//                i_pop          - read request (ignored when empty)
//                o_data         - head entry (0 when empty)
//                o_count        - occupancy, 0..DEPTH
//                o_full/o_empty - derived from o_count
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned c_PTR_W = $clog2(DEPTH);
  localparam int unsigned c_CNT_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign o_full  = (r_count == c_CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  // The slot freed by a same-cycle pop makes room for the push.
  assign w_push  = i_push && (!o_full || w_pop);

  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_queue
//  Description : Host command front end. Assembles 64-bit GEMM commands from
//                two 32-bit register writes, validates and buffers them, and
//                hands them to control_unit over a valid/ready handshake.
//                Tracks in-flight commands, a sticky IRQ and error flags.
//  Ports       : clk, rst_n                     - clock, sync active-low reset
//                host_wr_en/addr/data           - host register write port
//                cmd_valid, cmd_data, cmd_ready - command handshake
//                done_irq, busy                 - control_unit status
//                irq, q_count, inflight, idle   - host status
//                err_overflow/bad_cmd/spurious  - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_queue
  import tc_pkg::*;
#(
  parameter int unsigned DEPTH                = 4,
  parameter int unsigned ADDR_WIDTH           = 10,
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_wr_en,
  input  logic [1:0]               host_wr_addr,
  input  logic [31:0]              host_wr_data,
  output logic                     cmd_valid,
  output logic [63:0]              cmd_data,
  input  logic                     cmd_ready,
  input  logic                     done_irq,
  input  logic                     busy,
  output logic                     irq,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [3:0]               inflight,
  output logic                     idle,
  output logic                     err_overflow,
  output logic                     err_bad_cmd,
  output logic                     err_spurious
);

  // Three 8-bit lengths plus four address fields; 64 bits at the default width.
  localparam int unsigned c_CMD_W   = 24 + 4 * ADDR_WIDTH;
  localparam logic [3:0]  c_INF_MAX = 4'hF;

  logic [31:0] r_stage;
  logic        r_irq_en;
  logic        r_irq;
  logic [3:0]  r_inflight;
  logic        r_err_overflow;
  logic        r_err_bad_cmd;
  logic        r_err_spurious;

  logic        w_lo_wr;
  logic        w_hi_wr;
  logic        w_ctrl_wr;
  command_t    w_cmd;
  logic        w_legal;
  logic        w_push_try;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_ovf_set;
  logic        w_bad_set;
  logic        w_spur_set;
  logic        w_err_clr;

  assign w_lo_wr   = host_wr_en && (host_wr_addr == CMD_LO);
  assign w_hi_wr   = host_wr_en && (host_wr_addr == CMD_HI);
  assign w_ctrl_wr = host_wr_en && (host_wr_addr == CTRL);

  assign w_cmd      = command_t'({host_wr_data, r_stage});
  assign w_legal    = cmd_is_legal(w_cmd, SYSTOLIC_ARRAY_WIDTH);
  assign w_push_try = w_hi_wr && w_legal;
  assign w_pop      = !w_empty && cmd_ready;

  assign w_ovf_set  = w_push_try && w_full && !w_pop;
  assign w_bad_set  = w_hi_wr && !w_legal;
  // A completion with nothing outstanding is only spurious if no command is
  // being handed off in the same cycle to pair with it.
  assign w_spur_set = done_irq && !w_pop && (r_inflight == 4'd0);
  assign w_err_clr  = w_ctrl_wr && host_wr_data[CTRL_ERR_CLR];

  sync_fifo #(
    .WIDTH (c_CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_try),
    .i_data  (w_cmd),
    .i_pop   (cmd_ready),
    .o_data  (cmd_data),
    .o_count (q_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage        <= '0;
      r_irq_en       <= 1'b0;
      r_irq          <= 1'b0;
      r_inflight     <= '0;
      r_err_overflow <= 1'b0;
      r_err_bad_cmd  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      if (w_lo_wr)   r_stage  <= host_wr_data;
      if (w_ctrl_wr) r_irq_en <= host_wr_data[CTRL_IRQ_EN];

      // Set takes priority over a same-cycle clear.
      if (done_irq && r_irq_en)
        r_irq <= 1'b1;
      else if (w_ctrl_wr && host_wr_data[CTRL_IRQ_CLR])
        r_irq <= 1'b0;

      case ({w_pop, done_irq})
        2'b10: if (r_inflight != c_INF_MAX) r_inflight <= r_inflight + 4'd1;
        2'b01: if (r_inflight != 4'd0)      r_inflight <= r_inflight - 4'd1;
        default: r_inflight <= r_inflight;
      endcase

      r_err_overflow <= w_ovf_set  || (r_err_overflow && !w_err_clr);
      r_err_bad_cmd  <= w_bad_set  || (r_err_bad_cmd  && !w_err_clr);
      r_err_spurious <= w_spur_set || (r_err_spurious && !w_err_clr);
    end
  end

  assign cmd_valid    = !w_empty;
  assign irq          = r_irq;
  assign inflight     = r_inflight;
  assign idle         = w_empty && (r_inflight == 4'd0) && !busy;
  assign err_overflow = r_err_overflow;
  assign err_bad_cmd  = r_err_bad_cmd;
  assign err_spurious = r_err_spurious;

endmodule
`default_nettype wire

// File: tb/tb_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_queue
//  Description : Self-checking bench for cmd_queue. Directed scenarios followed
//                by random traffic, every cycle compared against a queue-based
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_queue;

  localparam int DEPTH = 4;
  localparam int W     = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_wr_en = 1'b0;
  logic [1:0]  host_wr_addr = 2'd0;
  logic [31:0] host_wr_data = 32'd0;
  logic        cmd_valid;
  logic [63:0] cmd_data;
  logic        cmd_ready = 1'b0;
  logic        done_irq = 1'b0;
  logic        busy = 1'b0;
  logic        irq;
  logic [2:0]  q_count;
  logic [3:0]  inflight;
  logic        idle;
  logic        err_overflow;
  logic        err_bad_cmd;
  logic        err_spurious;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [63:0] m_q[$];
  int          m_inflight;
  bit          m_irq, m_irq_en, m_ovf, m_badc, m_spur;
  logic [31:0] m_stage;

  cmd_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(10), .SYSTOLIC_ARRAY_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .done_irq     (done_irq),
    .busy         (busy),
    .irq          (irq),
    .q_count      (q_count),
    .inflight     (inflight),
    .idle         (idle),
    .err_overflow (err_overflow),
    .err_bad_cmd  (err_bad_cmd),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit len_ok(input logic [7:0] l);
    return (l >= 8'd1) && (l <= 8'(W));
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int          sz;
    bit          pop, push, ctrl, clr;
    bit          ovf, badc, spur;
    logic [63:0] c;
    if (!rst_n) begin
      m_q.delete();
      m_inflight = 0;
      m_irq = 0; m_irq_en = 0; m_ovf = 0; m_badc = 0; m_spur = 0;
      m_stage = '0;
      return;
    end
    sz   = m_q.size();
    pop  = (sz != 0) && cmd_ready;
    push = 0; ovf = 0; badc = 0; spur = 0;
    c    = '0;
    ctrl = host_wr_en && (host_wr_addr == 2'd2);
    clr  = ctrl && host_wr_data[2];
    if (host_wr_en && host_wr_addr == 2'd1) begin
      c = {host_wr_data, m_stage};
      if (!(len_ok(c[7:0]) && len_ok(c[15:8]) && len_ok(c[23:16]))) badc = 1;
      else if (sz < DEPTH || pop) push = 1;
      else ovf = 1;
    end
    if (host_wr_en && host_wr_addr == 2'd0) m_stage = host_wr_data;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(c);
    if (pop && !done_irq) begin
      if (m_inflight < 15) m_inflight++;
    end else if (!pop && done_irq) begin
      if (m_inflight == 0) spur = 1;
      else m_inflight--;
    end
    if (done_irq && m_irq_en) m_irq = 1;
    else if (ctrl && host_wr_data[1]) m_irq = 0;
    if (ctrl) m_irq_en = host_wr_data[0];
    m_ovf  = ovf  || (m_ovf  && !clr);
    m_badc = badc || (m_badc && !clr);
    m_spur = spur || (m_spur && !clr);
  endtask

  task automatic check_all();
    check_eq("cmd_valid", 64'(cmd_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) check_eq("cmd_data", cmd_data, m_q[0]);
    check_eq("q_count", 64'(q_count), 64'(m_q.size()));
    check_eq("inflight", 64'(inflight), 64'(m_inflight));
    check_eq("irq", 64'(irq), 64'(m_irq));
    check_eq("idle", 64'(idle), 64'(m_q.size() == 0 && m_inflight == 0 && !busy));
    check_eq("err_overflow", 64'(err_overflow), 64'(m_ovf));
    check_eq("err_bad_cmd", 64'(err_bad_cmd), 64'(m_badc));
    check_eq("err_spurious", 64'(err_spurious), 64'(m_spur));
  endtask

  // One clock: drive on the falling edge, model on the rising edge, check 1ns later.
  task automatic cyc(input bit we, input bit [1:0] a, input bit [31:0] d,
                     input bit rdy, input bit dn);
    @(negedge clk);
    host_wr_en   = we;
    host_wr_addr = a;
    host_wr_data = d;
    cmd_ready    = rdy;
    done_irq     = dn;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  function automatic logic [31:0] mk_lo(input logic [7:0] lm, input logic [7:0] lk,
                                        input logic [7:0] ln, input logic [9:0] aa);
    return {aa[7:0], ln, lk, lm};
  endfunction

  function automatic logic [31:0] mk_hi(input logic [9:0] aa, input logic [9:0] ab,
                                        input logic [9:0] ac, input logic [9:0] ad);
    return {ad, ac, ab, aa[9:8]};
  endfunction

  initial begin
    // Reset state
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_eq("rst_cmd_data", cmd_data, 64'h0);
    rst_n = 1'b1;

    // Single command with ready held: valid for exactly one cycle, then inflight=1
    cyc(1, 0, mk_lo(8, 8, 8, 10'h3FF), 1, 0);
    cyc(1, 1, mk_hi(10'h3FF, 10'h300, 10'h200, 10'h100), 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);

    // Fill to DEPTH with ready low; fifth commit overflows
    cyc(1, 0, mk_lo(1, 2, 3, 10'h155), 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(1, 1, mk_hi(10'h155, 10'(i), 10'(i * 3), 10'(i * 7 + 1)), 0, 0);
    repeat (5) cyc(0, 0, 0, 1, 0);

    // Illegal lengths, then error clear
    cyc(1, 0, mk_lo(8, 0, 8, 0), 0, 0);
    cyc(1, 1, 32'h1234_5678, 0, 0);
    cyc(1, 0, mk_lo(8, 8, 17, 0), 0, 0);
    cyc(1, 1, 32'h0, 0, 0);
    cyc(1, 0, mk_lo(16, 16, 16, 0), 0, 0);
    cyc(1, 1, 32'hABCD_0001, 0, 0);
    cyc(1, 2, 32'h4, 1, 0);

    // IRQ enable, completion, clear-versus-set priority
    cyc(1, 2, 32'h1, 1, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 1, 32'h5555_5555, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 2, 32'h3, 1, 1);
    cyc(1, 2, 32'h3, 1, 0);
    cyc(1, 2, 32'h0, 1, 0);

    // Spurious completion, then pop + done in the same cycle
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 32'h0F0F_0F0F, 0, 0);
    cyc(1, 1, 32'h7777_0000, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);

    // Mid-operation reset discards queued work
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'(i * 32'h1111), 0, 0);
    rst_n = 1'b0;
    cyc(0, 0, 0, 1, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // Random traffic
    for (int t = 0; t < 1500; t++) begin
      bit          we, rdy, dn;
      bit [1:0]    a;
      bit [31:0]   d;
      busy  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      we    = ($urandom_range(0, 1) == 1);
      a     = 2'($urandom_range(0, 3));
      d     = $urandom;
      case (a)
        2'd0: d = mk_lo(8'($urandom_range(0, 17)), 8'($urandom_range(0, 17)),
                        8'($urandom_range(0, 17)), 10'($urandom));
        2'd2: d = {29'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) != 0)};
        default: ;
      endcase
      rdy = ($urandom_range(0, 2) != 0);
      dn  = ($urandom_range(0, 4) == 0);
      cyc(we, a, d, rdy, dn);
    end
    rst_n = 1'b1;
    busy  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
